// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port data memory between master 0 (CPU load/store unit)
// and master 1 (DMA / program loader). Round-robin arbitration, one access per
// grant, with an optional per-master lock for atomic back-to-back bursts.
//
// Optional build macro: DMEM_ARB_LOCK_TIMEOUT_EN
//   defined   : a locked burst is force-released after MAX_LOCK consecutive
//               grants and lock_err pulses for one cycle.
//   undefined : locks are unbounded, lock_err is tied to 0.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   mX_req/we/lock/addr/wdata  master X request, held stable until mX_gnt
//   mX_gnt                     access performed this cycle for master X
//   mX_rvalid/mX_rdata         read return, one cycle after a read grant
//   lock_err                   one-cycle pulse on a forced lock release
//   CS, DM_W, DM_R             memory strobes, decoded from the grant state
//   addr, wdata                memory address / write data of the owner
//   rdata                      combinational read data from the memory
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              lock_err,
    output logic              CS,
    output logic              DM_W,
    output logic              DM_R,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                last_owner_r;
    logic                m0_rvalid_r;
    logic                m1_rvalid_r;
    logic [DATA_W-1:0]   m0_rdata_r;
    logic [DATA_W-1:0]   m1_rdata_r;
    logic                owner_lock_s;
    logic                lock_limit_s;
    logic                lock_stay_s;
    logic                owner_we_s;
    logic [ADDR_W-1:0]   owner_addr_s;
    logic [DATA_W-1:0]   owner_wdata_s;
    logic                any_gnt_s;

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    logic [7:0]          lock_cnt_r;
    logic                lock_err_r;

    // lock_cnt_r holds (grants so far in this burst - 1); the limit is hit on
    // the MAX_LOCK-th grant of the burst.
    assign lock_limit_s = (lock_cnt_r == 8'(MAX_LOCK - 1));
    assign lock_err     = lock_err_r;

    // Locked-burst length counter and forced-release error pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_cnt_r <= 8'd0;
            lock_err_r <= 1'b0;
        end else begin
            lock_err_r <= owner_lock_s && lock_limit_s;
            if (lock_stay_s) begin
                lock_cnt_r <= lock_cnt_r + 8'd1;
            end else begin
                lock_cnt_r <= 8'd0;
            end
        end
    end
`else
    assign lock_limit_s = 1'b0;
    assign lock_err     = 1'b0;
`endif

    // Owner still wants the bus: lock and req both asserted by the current owner.
    assign owner_lock_s = ((state_r == ST_GNT0) && m0_lock && m0_req) ||
                          ((state_r == ST_GNT1) && m1_lock && m1_req);
    assign lock_stay_s  = owner_lock_s && !lock_limit_s;

    // Next-state logic: round-robin from IDLE, lock/handover from a grant.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt_s = last_owner_r ? ST_GNT0 : ST_GNT1;
                end else if (m0_req) begin
                    state_nxt_s = ST_GNT0;
                end else if (m1_req) begin
                    state_nxt_s = ST_GNT1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (lock_stay_s) begin
                    state_nxt_s = ST_GNT0;
                end else if (m1_req) begin
                    state_nxt_s = ST_GNT1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (lock_stay_s) begin
                    state_nxt_s = ST_GNT1;
                end else if (m0_req) begin
                    state_nxt_s = ST_GNT0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Owner mux for the memory-side access fields; zero when nobody owns the bus.
    always_comb begin
        owner_we_s    = 1'b0;
        owner_addr_s  = {ADDR_W{1'b0}};
        owner_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            ST_GNT0: begin
                owner_we_s    = m0_we;
                owner_addr_s  = m0_addr;
                owner_wdata_s = m0_wdata;
            end
            ST_GNT1: begin
                owner_we_s    = m1_we;
                owner_addr_s  = m1_addr;
                owner_wdata_s = m1_wdata;
            end
            default: begin
                owner_we_s    = 1'b0;
                owner_addr_s  = {ADDR_W{1'b0}};
                owner_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // State register, round-robin history and registered read return.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            last_owner_r <= 1'b1;
            m0_rvalid_r  <= 1'b0;
            m1_rvalid_r  <= 1'b0;
            m0_rdata_r   <= {DATA_W{1'b0}};
            m1_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_GNT0) begin
                last_owner_r <= 1'b0;
            end else if (state_r == ST_GNT1) begin
                last_owner_r <= 1'b1;
            end else begin
                last_owner_r <= last_owner_r;
            end
            m0_rvalid_r <= (state_r == ST_GNT0) && !m0_we;
            m1_rvalid_r <= (state_r == ST_GNT1) && !m1_we;
            if ((state_r == ST_GNT0) && !m0_we) begin
                m0_rdata_r <= rdata;
            end
            if ((state_r == ST_GNT1) && !m1_we) begin
                m1_rdata_r <= rdata;
            end
        end
    end

    assign m0_gnt    = (state_r == ST_GNT0);
    assign m1_gnt    = (state_r == ST_GNT1);
    assign m0_rvalid = m0_rvalid_r;
    assign m1_rvalid = m1_rvalid_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;

    // The strobes are qualified with reset so that an access whose grant cycle
    // ends on a reset edge never commits to the memory.
    assign any_gnt_s = m0_gnt | m1_gnt;
    assign CS        = any_gnt_s & reset;
    assign DM_W      = CS & owner_we_s;
    assign DM_R      = CS & ~owner_we_s;
    assign addr      = owner_addr_s;
    assign wdata     = owner_wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// arbitration/memory model and randomized two-master traffic.
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 4;
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, lock_err, CS, DM_W, DM_R;
    logic [31:0] m0_rdata, m1_rdata, addr, wdata, rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .lock_err(lock_err), .CS(CS), .DM_W(DM_W), .DM_R(DM_R),
        .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Environment memory (256 words, word index = addr[9:2]).
    logic [31:0] tmem [0:255];
    assign rdata = tmem[addr[9:2]];
    always @(posedge clk) if (DM_W === 1'b1) tmem[addr[9:2]] <= wdata;

    // Reference model state: owner (-1 none), last owner, grants in current run.
    int          own = -1;
    int          last = 1;
    int          burst = 0;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          exp_err;
    bit          served [2];
    logic [31:0] mm [0:255];

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [135:0] obs_vec();
        return {m0_gnt, m1_gnt, CS, DM_W, DM_R, addr, wdata,
                m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, lock_err};
    endfunction

    function automatic logic [135:0] exp_vec();
        logic cs, we;
        logic [31:0] a, d;
        cs = (own >= 0) && (reset == 1'b1);
        we = 1'b0; a = 32'd0; d = 32'd0;
        if (own == 0) begin we = m0_we; a = m0_addr; d = m0_wdata; end
        else if (own == 1) begin we = m1_we; a = m1_addr; d = m1_wdata; end
        return {own == 0, own == 1, cs, cs && we, cs && !we, a, d,
                exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1], exp_err};
    endfunction

    task automatic drive(input int m, input bit rq, input bit we, input bit lk,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_req = rq; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d; end
        else begin m1_req = rq; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d; end
    endtask

    // Advance one clock: apply the arbitration rules to the inputs of the
    // cycle that is ending, then move to the next cycle.
    task automatic step();
        int nown, nlast, nburst;
        bit nerr, rq_own, rq_oth, lk_own, we_own, rst;
        bit nrv [2];
        logic [31:0] a_own, d_own;
        served[0] = 1'b0; served[1] = 1'b0;
        nrv[0] = 1'b0; nrv[1] = 1'b0;
        nerr = 1'b0; nown = -1; nlast = last; nburst = 0;
        rst = (reset == 1'b1);
        if (own >= 0) begin
            rq_own = (own == 0) ? m0_req : m1_req;
            rq_oth = (own == 0) ? m1_req : m0_req;
            lk_own = (own == 0) ? m0_lock : m1_lock;
            we_own = (own == 0) ? m0_we : m1_we;
            a_own  = (own == 0) ? m0_addr : m1_addr;
            d_own  = (own == 0) ? m0_wdata : m1_wdata;
            nlast  = own;
            if (rst) begin
                served[own] = 1'b1;
                if (we_own) mm[a_own[9:2]] = d_own;
                else begin nrv[own] = 1'b1; exp_rd[own] = mm[a_own[9:2]]; end
            end
            if (lk_own && rq_own && !(TO_EN && burst >= MAX_LOCK)) begin
                nown = own; nburst = burst + 1;
            end else begin
                nerr = lk_own && rq_own;
                nown = rq_oth ? 1 - own : -1;
                nburst = 1;
            end
        end else begin
            if (m0_req && m1_req) nown = (last == 1) ? 0 : 1;
            else if (m0_req) nown = 0;
            else if (m1_req) nown = 1;
            nburst = 1;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            own = -1; last = 1; burst = 0; exp_err = 1'b0;
            exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
            served[0] = 1'b0; served[1] = 1'b0;
        end else begin
            own = nown; last = nlast; burst = nburst; exp_err = nerr;
            exp_rv[0] = nrv[0]; exp_rv[1] = nrv[1];
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL idle_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({m0_gnt, m1_gnt, CS, m0_rvalid, m1_rvalid, lock_err} !== 6'b0)
                $display("FAIL reset_outs: got %b exp 000000", {m0_gnt, m1_gnt, CS, m0_rvalid, m1_rvalid, lock_err});
            else n_pass++;
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL reset_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
        end
        reset = 1'b1;
        step();
        n_chk++;
        if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL reset_first_tie: got %b exp 10", {m0_gnt, m1_gnt}); else n_pass++;
        n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL reset_rel_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
        idle_all();
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        step();
        n_chk++;
        if ({m0_gnt, CS, DM_W, addr} !== {3'b111, 32'h40})
            $display("FAIL wr_gnt: got %b%b%b addr %h exp 111 addr 00000040", m0_gnt, CS, DM_W, addr);
        else n_pass++;
        step();
        n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL wr_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
        idle_all();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        step();
        n_chk++; if (m0_gnt !== 1'b1) $display("FAIL rd_gnt: got %b exp 1", m0_gnt); else n_pass++;
        step();
        n_chk++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL rd_data: got %b %h exp 1 deadbeef", m0_rvalid, m0_rdata);
        else n_pass++;
        n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL rd_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
        idle_all();
    endtask

    task automatic test_round_robin();
        int n0, n1;
        logic prev0;
        n0 = 0; n1 = 0; prev0 = 1'bx;
        drive(0, 1'b1, 1'b0, 1'b0, $urandom, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b0, $urandom, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL rr_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
            if (m0_gnt === 1'b1) n0++;
            if (m1_gnt === 1'b1) n1++;
            if (i > 0) begin
                n_chk++;
                if ((m0_gnt ^ m1_gnt) !== 1'b1 || m0_gnt === prev0)
                    $display("FAIL rr_alt: got gnt %b%b prev m0 %b exp one grant, alternating", m0_gnt, m1_gnt, prev0);
                else n_pass++;
            end
            prev0 = m0_gnt;
            if (served[0]) m0_addr = $urandom;
            if (served[1]) m1_addr = $urandom;
        end
        n_chk++;
        if (n0 != 10 || n1 != 10) $display("FAIL rr_fair: got %0d/%0d exp 10/10", n0, n1); else n_pass++;
        idle_all();
    endtask

    task automatic test_lock_burst();
        int i;
        i = 0;
        drive(0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0);
        for (int s = 1; s <= 6; s++) begin
            step();
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL lock_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
            if (s <= 4) begin
                n_chk++; if (m0_gnt !== 1'b1) $display("FAIL lock_m0_gnt%0d: got %b exp 1", s, m0_gnt); else n_pass++;
            end
            if (s == 5) begin
                n_chk++; if (m1_gnt !== 1'b1) $display("FAIL lock_m1_gnt: got %b exp 1", m1_gnt); else n_pass++;
            end
            if (s >= 2 && s <= 5) begin
                n_chk++;
                if ({m0_rvalid, m0_rdata} !== {1'b1, mm[s-2]})
                    $display("FAIL lock_rdata%0d: got %b %h exp 1 %h", s, m0_rvalid, m0_rdata, mm[s-2]);
                else n_pass++;
            end
            if (s == 1) drive(1, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
            if (served[0]) begin
                i++;
                if (i < 4) drive(0, 1'b1, 1'b0, (i < 3), 32'(i * 4), 32'd0);
                else drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (served[1]) drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        idle_all();
    endtask

    task automatic test_lock_timeout();
        drive(0, 1'b1, 1'b0, 1'b1, $urandom, 32'd0);
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
        for (int s = 1; s <= 6; s++) begin
            step();
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL to_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
            n_chk++;
            if (s <= 4 && {m0_gnt, lock_err} !== 2'b10)
                $display("FAIL to_m0_%0d: got gnt/err %b%b exp 10", s, m0_gnt, lock_err);
            else if (s == 5 && {m1_gnt, lock_err} !== 2'b11)
                $display("FAIL to_release: got gnt/err %b%b exp 11", m1_gnt, lock_err);
            else if (s == 6 && lock_err !== 1'b0)
                $display("FAIL to_pulse: got %b exp 0", lock_err);
            else n_pass++;
            if (s == 1) drive(1, 1'b1, 1'b0, 1'b0, $urandom, 32'd0);
            if (served[0]) begin
                if (s < 5) m0_addr = $urandom;
                else drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (served[1]) drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
`else
        for (int s = 1; s <= 10; s++) begin
            step();
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL nolim_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
            n_chk++;
            if ({m0_gnt, lock_err} !== 2'b10) $display("FAIL nolim_%0d: got gnt/err %b%b exp 10", s, m0_gnt, lock_err);
            else n_pass++;
            if (s == 1) drive(1, 1'b1, 1'b0, 1'b0, $urandom, 32'd0);
            if (served[0]) m0_addr = $urandom;
        end
`endif
        idle_all();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] orig;
        orig = mm[33];
        drive(1, 1'b1, 1'b1, 1'b1, 32'h80, 32'hA5A5_0001);
        step();
        n_chk++; if (m1_gnt !== 1'b1) $display("FAIL rst_burst_g1: got %b exp 1", m1_gnt); else n_pass++;
        step();
        n_chk++; if (m1_gnt !== 1'b1) $display("FAIL rst_burst_g2: got %b exp 1", m1_gnt); else n_pass++;
        drive(1, 1'b1, 1'b1, 1'b1, 32'h84, 32'hA5A5_0002);
        reset = 1'b0;
        #1;
        n_chk++; if ({CS, DM_W} !== 2'b00) $display("FAIL rst_strobe: got %b exp 00", {CS, DM_W}); else n_pass++;
        step();
        n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL rst_burst_vec: got %h exp %h", obs_vec(), exp_vec()); else n_pass++;
        n_chk++;
        if (tmem[33] !== orig || tmem[32] !== 32'hA5A5_0001)
            $display("FAIL rst_commit: got %h %h exp %h a5a50001", tmem[33], tmem[32], orig);
        else n_pass++;
        reset = 1'b1;
        idle_all();
    endtask

    task automatic test_random();
        bit cur;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                cur = (m == 0) ? m0_req : m1_req;
                if (served[m] || !cur)
                    drive(m, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 2) == 0), $urandom, $urandom);
            end
            step();
            n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL rand_vec%0d: got %h exp %h", c, obs_vec(), exp_vec()); else n_pass++;
        end
        idle_all();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            tmem[k] = $urandom;
            mm[k] = tmem[k];
        end
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; exp_err = 1'b0;
        served[0] = 1'b0; served[1] = 1'b0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock_burst();
        test_lock_timeout();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
